// File: rtl/addsub_pkg.sv
// addsub_pkg: shared configuration helpers for the pipelined adder/subtractor.
package addsub_pkg;
   function automatic int stages_f(input int width, input int seg);
      return width / seg;
   endfunction
   function automatic bit cfg_ok(input int width, input int seg);
      return seg >= 1 && seg <= width && width % seg == 0;
   endfunction
endpackage

// File: rtl/add_seg.sv
// add_seg: combinational SEG-bit ripple segment exposing the carry into its top bit.
module add_seg #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           c_msb_in
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
   assign c_msb_in = a[SEG-1] ^ b[SEG-1] ^ s[SEG-1];
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: carry-pipelined WIDTH-bit adder/subtractor, one SEG-bit segment per stage.
// Each stage rotates its word right by SEG, so pending operand segments and finished sums share one register.
module pipe_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int STAGES = stages_f(WIDTH, SEG);
   if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
      $error("pipe_addsub: SEG must divide WIDTH and lie in 1..WIDTH");
   end
   logic [WIDTH-1:0] aw [STAGES];
   logic [WIDTH-1:0] bw [STAGES];
   logic             ci [STAGES];
   logic             vi [STAGES];
   logic             stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign aw[0]    = a;
   assign bw[0]    = sub ? ~b : b;
   assign ci[0]    = cin ^ sub;
   assign vi[0]    = in_valid;
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic [SEG-1:0]   s_seg;
      logic             co, cm, c_d, c_q, v_d, v_q;
      logic [WIDTH-1:0] w_d, w_q;
      add_seg #(.SEG(SEG)) u_seg (
         .a        (aw[k][SEG-1:0]),
         .b        (bw[k][SEG-1:0]),
         .ci       (ci[k]),
         .s        (s_seg),
         .co       (co),
         .c_msb_in (cm)
      );
      always_comb begin
         w_d = stall ? w_q : (WIDTH'(s_seg) << (WIDTH - SEG)) | (aw[k] >> SEG);
         c_d = stall ? c_q : co;
         v_d = stall ? v_q : vi[k];
      end
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            w_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end else begin
            w_q <= w_d;
            c_q <= c_d;
            v_q <= v_d;
         end
      end
      if (k < STAGES - 1) begin : g_mid
         logic [WIDTH-1:0] b_d, b_q;
         logic             cm_unused;
         assign cm_unused = cm;
         always_comb b_d = stall ? b_q : bw[k] >> SEG;
         always_ff @(posedge clk) b_q <= b_d;
         assign aw[k+1] = w_q;
         assign bw[k+1] = b_q;
         assign ci[k+1] = c_q;
         assign vi[k+1] = v_q;
      end else begin : g_last
         logic [WIDTH-1:0] b_unused;
         logic             o_d, o_q;
         assign b_unused = bw[k];
         always_comb o_d = stall ? o_q : cm ^ co;
         always_ff @(posedge clk) begin
            if (!rst_n) o_q <= 1'b0;
            else o_q <= o_d;
         end
         assign s         = w_q;
         assign cout      = c_q;
         assign ovf       = o_q;
         assign out_valid = v_q;
      end
   end
endmodule
